// File: rtl/core_frame_fetch_pkg.sv
// Shared definitions for the per-core frame fetch stage.
package core_frame_fetch_pkg;

  localparam int DEF_INSN_WIDTH  = 16;
  localparam int DEF_FRAME_INSNS = 16;
  localparam int DEF_R0_WIDTH    = 16;
  localparam int NUM_CORES       = 4;

  // Top nibble of an instruction that ends the frame early.
  localparam logic [3:0] OPC_STOP = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/core_frame_fetch_slot_mux.sv
// Combinational selection of one instruction slot from the latched frame.
module frame_slot_mux
  #(
    parameter int INSN_WIDTH  = 16,
    parameter int FRAME_INSNS = 16
  ) (
    input  logic [FRAME_INSNS*INSN_WIDTH-1:0]  frame,
    input  logic [$clog2(FRAME_INSNS)-1:0]     sel,
    output logic [INSN_WIDTH-1:0]              slot
  );

  assign slot = frame[sel*INSN_WIDTH +: INSN_WIDTH];

endmodule

// File: rtl/core_frame_fetch.sv
// Per-core frame fetch: latches a frame on start, issues it slot by slot
// over valid/ready, then waits for the core to drain before going idle.
module core_frame_fetch
  import core_frame_fetch_pkg::*;
  #(
    parameter int INSN_WIDTH  = DEF_INSN_WIDTH,
    parameter int FRAME_INSNS = DEF_FRAME_INSNS,
    parameter int R0_WIDTH    = DEF_R0_WIDTH
  ) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [FRAME_INSNS*INSN_WIDTH-1:0]  insn_data,
    input  logic                               init_r0_en,
    input  logic [R0_WIDTH-1:0]                init_r0,
    output logic                               ready,
    output logic [INSN_WIDTH-1:0]              insn,
    output logic [$clog2(FRAME_INSNS)-1:0]     insn_pc,
    output logic                               insn_valid,
    input  logic                               insn_ready,
    output logic                               r0_we,
    output logic [R0_WIDTH-1:0]                r0_wdata,
    input  logic                               core_idle,
    output logic                               frame_done
  );

  localparam int PC_W = $clog2(FRAME_INSNS);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(FRAME_INSNS - 1);

  fetch_state_t                      state;
  logic [FRAME_INSNS*INSN_WIDTH-1:0] frame;
  logic [PC_W-1:0]                   pc;
  logic                              is_stop;

  frame_slot_mux #(
    .INSN_WIDTH  (INSN_WIDTH),
    .FRAME_INSNS (FRAME_INSNS)
  ) u_mux (
    .frame (frame),
    .sel   (pc),
    .slot  (insn)
  );

  assign insn_pc = pc;
  assign is_stop = (insn[INSN_WIDTH-1 -: 4] == OPC_STOP);

  // Done is qualified by the drain state so it can fire the same cycle
  // core_idle rises; reset suppresses it so an abandoned frame never reports.
  assign frame_done = (state == S_DRAIN) && core_idle && !reset;

  // Fetch FSM with pc counter, frame register and R0 holding regs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      frame      <= '0;
      pc         <= '0;
      ready      <= 1'b1;
      insn_valid <= 1'b0;
      r0_we      <= 1'b0;
      r0_wdata   <= '0;
    end else begin
      // R0 strobe lives for the first issue cycle only.
      r0_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            frame      <= insn_data;
            pc         <= '0;
            r0_we      <= init_r0_en;
            r0_wdata   <= init_r0;
            ready      <= 1'b0;
            insn_valid <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (insn_valid && insn_ready) begin
            // Last slot or STOP: the accepted insn is the final one, pc stays.
            if (pc == PC_LAST || is_stop) begin
              insn_valid <= 1'b0;
              state      <= S_DRAIN;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (core_idle) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          ready      <= 1'b1;
          insn_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_frame_fetch.sv
// Directed bench for core_frame_fetch.
module tb_core_frame_fetch;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [255:0] insn_data = '0;
  logic         init_r0_en = 1'b0;
  logic [15:0]  init_r0 = '0;
  logic         ready, insn_valid, r0_we, frame_done;
  logic [15:0]  insn, r0_wdata;
  logic [3:0]   insn_pc;
  logic         insn_ready = 1'b0;
  logic         core_idle = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int r0_cnt  = 0;
  int fd_cnt  = 0;
  int exp_pc;
  logic [15:0] got_q[$];
  logic [3:0]  pc_q[$];

  always #5 clk = ~clk;

  core_frame_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .insn_data  (insn_data),
    .init_r0_en (init_r0_en),
    .init_r0    (init_r0),
    .ready      (ready),
    .insn       (insn),
    .insn_pc    (insn_pc),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .r0_we      (r0_we),
    .r0_wdata   (r0_wdata),
    .core_idle  (core_idle),
    .frame_done (frame_done)
  );

  // Transfer / strobe monitor.
  always @(posedge clk) begin
    if (!reset) begin
      if (insn_valid && insn_ready) begin
        got_q.push_back(insn);
        pc_q.push_back(insn_pc);
      end
      if (r0_we)      r0_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] slot_val(input logic [15:0] base, input int k,
                                           input int stop_slot, input logic [15:0] stop_val);
    return (k == stop_slot) ? stop_val : base + 16'(k);
  endfunction

  function automatic logic [255:0] mk_frame(input logic [15:0] base, input int stop_slot,
                                            input logic [15:0] stop_val);
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) f[k*16 +: 16] = slot_val(base, k, stop_slot, stop_val);
    return f;
  endfunction

  task automatic start_frame(input logic [255:0] f, input logic en, input logic [15:0] r0);
    insn_data  = f;
    init_r0_en = en;
    init_r0    = r0;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    for (int i = 0; i < budget && !ready; i++) cyc();
    chk(tag, 32'(ready), 1);
  endtask

  task automatic clr_q;
    got_q.delete();
    pc_q.delete();
  endtask

  task automatic chk_stream(input string tag, input logic [15:0] base, input int stop_slot,
                            input logic [15:0] stop_val);
    int n;
    n = (stop_slot < 0) ? 16 : stop_slot + 1;
    chk({tag, "_len"}, 32'(got_q.size()), 32'(n));
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      chk({tag, "_insn"}, 32'(got_q[k]), 32'(slot_val(base, k, stop_slot, stop_val)));
      chk({tag, "_pc"}, 32'(pc_q[k]), 32'(k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) cyc();
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_valid", 32'(insn_valid), 0);
    chk("rst_insn", 32'(insn), 0);
    chk("rst_pc", 32'(insn_pc), 0);
    chk("rst_r0we", 32'(r0_we), 0);
    chk("rst_r0data", 32'(r0_wdata), 0);
    chk("rst_done", 32'(frame_done), 0);
    reset = 1'b0;
    cyc();

    // Full 16-slot frame, no backpressure
    clr_q();
    insn_ready = 1'b1;
    core_idle  = 1'b1;
    start_frame(mk_frame(16'h0100, -1, 16'h0), 1'b0, 16'h0);
    #1;
    chk("full_ready_lo", 32'(ready), 0);
    chk("full_r0we", 32'(r0_we), 0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin cyc(); #1; end
      chk("full_valid", 32'(insn_valid), 1);
      chk("full_insn", 32'(insn), 32'(16'h0100 + 16'(k)));
      chk("full_pc", 32'(insn_pc), 32'(k));
    end
    cyc(); #1;
    chk("full_n17_valid", 32'(insn_valid), 0);
    chk("full_n17_done", 32'(frame_done), 1);
    chk("full_n17_ready", 32'(ready), 0);
    cyc(); #1;
    chk("full_n18_ready", 32'(ready), 1);
    chk("full_n18_done", 32'(frame_done), 0);
    chk_stream("full", 16'h0100, -1, 16'h0);

    // Early STOP at slot 3; done withheld until core_idle
    clr_q();
    fd_cnt    = 0;
    core_idle = 1'b0;
    start_frame(mk_frame(16'h0200, 3, 16'hF000), 1'b0, 16'h0);
    repeat (8) cyc();
    #1;
    chk_stream("stop", 16'h0200, 3, 16'hF000);
    chk("stop_valid", 32'(insn_valid), 0);
    chk("stop_ready", 32'(ready), 0);
    chk("stop_done_held", 32'(frame_done), 0);
    chk("stop_fd_cnt0", 32'(fd_cnt), 0);
    core_idle = 1'b1;
    #1;
    chk("stop_done", 32'(frame_done), 1);
    cyc(); #1;
    chk("stop_ready_back", 32'(ready), 1);
    chk("stop_done_off", 32'(frame_done), 0);
    chk("stop_fd_cnt1", 32'(fd_cnt), 1);

    // Backpressure: insn_ready pattern 1,0,0,1
    clr_q();
    start_frame(mk_frame(16'h0300, 5, 16'hF305), 1'b0, 16'h0);
    exp_pc = 0;
    for (int i = 0; i < 40 && exp_pc <= 5; i++) begin
      insn_ready = ((i % 4) == 0) || ((i % 4) == 3);
      #1;
      chk("bp_valid", 32'(insn_valid), 1);
      chk("bp_insn", 32'(insn), 32'(slot_val(16'h0300, exp_pc, 5, 16'hF305)));
      chk("bp_pc", 32'(insn_pc), 32'(exp_pc));
      if (insn_ready) exp_pc++;
      cyc();
    end
    #1;
    chk("bp_valid_end", 32'(insn_valid), 0);
    insn_ready = 1'b1;
    run_until_idle("bp_idle", 20);
    chk_stream("bp", 16'h0300, 5, 16'hF305);

    // R0 init with insn_ready low
    r0_cnt     = 0;
    insn_ready = 1'b0;
    start_frame(mk_frame(16'h0400, 0, 16'hF0AA), 1'b1, 16'h1111);
    #1;
    chk("r0_we", 32'(r0_we), 1);
    chk("r0_wdata", 32'(r0_wdata), 32'h1111);
    chk("r0_valid", 32'(insn_valid), 1);
    cyc(); #1;
    chk("r0_we_once", 32'(r0_we), 0);
    chk("r0_still_valid", 32'(insn_valid), 1);
    insn_ready = 1'b1;
    run_until_idle("r0_idle", 20);
    chk("r0_cnt1", 32'(r0_cnt), 1);
    r0_cnt = 0;
    start_frame(mk_frame(16'h0400, 0, 16'hF0AA), 1'b0, 16'h2222);
    #1;
    chk("r0_dis_we", 32'(r0_we), 0);
    run_until_idle("r0_dis_idle", 20);
    chk("r0_cnt0", 32'(r0_cnt), 0);

    // Start pulsed mid-ISSUE must be ignored
    clr_q();
    start_frame(mk_frame(16'h0500, 7, 16'hF507), 1'b0, 16'h0);
    cyc();
    cyc();
    insn_data = mk_frame(16'h0900, -1, 16'h0);
    start     = 1'b1;
    cyc();
    start     = 1'b0;
    run_until_idle("ign_idle", 30);
    chk_stream("ign", 16'h0500, 7, 16'hF507);
    cyc(); #1;
    chk("ign_no_restart", 32'(insn_valid), 0);

    // Reset mid-frame at pc 5
    clr_q();
    fd_cnt = 0;
    start_frame(mk_frame(16'h0600, -1, 16'h0), 1'b0, 16'h0);
    repeat (5) cyc();
    #1;
    chk("mid_pc5", 32'(insn_pc), 5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_ready", 32'(ready), 1);
    chk("mid_valid", 32'(insn_valid), 0);
    chk("mid_done", 32'(frame_done), 0);
    chk("mid_pc0", 32'(insn_pc), 0);
    cyc();
    chk("mid_fd_cnt", 32'(fd_cnt), 0);
    clr_q();
    start_frame(mk_frame(16'h0700, 2, 16'hF702), 1'b0, 16'h0);
    #1;
    chk("fresh_pc", 32'(insn_pc), 0);
    chk("fresh_insn", 32'(insn), 32'h0700);
    run_until_idle("fresh_idle", 20);
    chk_stream("fresh", 16'h0700, 2, 16'hF702);
    chk("fresh_fd_cnt", 32'(fd_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
